// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, status and baud registers.
module mmio_uart_tx #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h0000_1000),
  parameter int unsigned           FIFO_DEPTH   = 8,
  parameter logic [15:0]           BAUD_DIV_RST = 16'd867
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic [3:0]            wr_mask_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  tx_o,
  output logic                  irq_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state, state_n;
  logic            hit, is_wr, push_req, push_ok, pop, ovf_clr, full, empty, bit_end;
  logic [1:0]      offset;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_n;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [15:0]     baud_div, baud_cnt, baud_cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            tx_n;
  logic            ovf;
  logic [DATA_WIDTH-1:0] rd_data;
  logic            unused_bits;

  assign unused_bits = ^{address_i[1:0], data_in_i[DATA_WIDTH-1:16]};

  assign hit      = en && (address_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign offset   = address_i[3:2];
  assign is_wr    = |wr_mask_i;
  assign push_req = hit && is_wr && (offset == 2'd0) && wr_mask_i[0];
  assign ovf_clr  = hit && is_wr && (offset == 2'd1) && wr_mask_i[0] && data_in_i[3];
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push_req && !full;
  assign bit_end  = (baud_cnt == '0);
  assign count_n  = count + CW'(push_ok) - CW'(pop);

  // Register read multiplexer, evaluated on pre-edge state.
  always_comb begin
    rd_data = '0;
    unique case (offset)
      2'd1: begin
        rd_data[0]    = (state != S_IDLE);
        rd_data[1]    = full;
        rd_data[2]    = empty;
        rd_data[3]    = ovf;
        rd_data[15:8] = 8'(count);
      end
      2'd2:    rd_data[15:0] = baud_div;
      default: rd_data = '0;
    endcase
  end

  // Serialiser next-state: the bit timer reloads from BAUDDIV at every bit boundary,
  // and the stop bit chains straight into the next start bit when data is waiting.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    tx_n       = tx_o;
    pop        = 1'b0;
    if (state != S_IDLE) begin
      baud_cnt_n = bit_end ? baud_div : baud_cnt - 16'd1;
    end
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_n    = S_START;
          tx_n       = 1'b0;
          shreg_n    = fifo_mem[rd_ptr];
          baud_cnt_n = baud_div;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n   = S_DATA;
          tx_n      = shreg[0];
          shreg_n   = {1'b0, shreg[7:1]};
          bit_idx_n = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shreg[0];
            shreg_n   = {1'b0, shreg[7:1]};
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = S_START;
            tx_n    = 1'b0;
            shreg_n = fifo_mem[rd_ptr];
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= data_in_i[7:0];
  end

  // FIFO pointers, overflow flag, baud register and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      baud_div   <= BAUD_DIV_RST;
      data_out_o <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count <= count_n;
      if (push_req && full) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;
      if (hit && is_wr && (offset == 2'd2)) begin
        if (wr_mask_i[0]) baud_div[7:0]  <= data_in_i[7:0];
        if (wr_mask_i[1]) baud_div[15:8] <= data_in_i[15:8];
      end
      data_out_o <= (hit && !is_wr) ? rd_data : '0;
    end
  end

  // Serialiser state, line output and TX-done interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_o     <= 1'b1;
      irq_o    <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      tx_o     <= tx_n;
      irq_o    <= (count_n == '0) && (state_n == S_IDLE);
    end
  end

endmodule
